// File: rtl/date_set_pkg.sv
// Shared types and constants for the date/time set controller.
package date_set_pkg;

   localparam int unsigned NFIELD  = 7;
   localparam int unsigned FIELD_W = 3;

   typedef enum logic [2:0] {
      RUN, S_HOUR, S_MIN, S_SEC, S_DAY, S_MONTH, S_YEAR, S_CEN
   } state_e;

   localparam logic [FIELD_W-1:0] F_SEC   = 3'd0;
   localparam logic [FIELD_W-1:0] F_MIN   = 3'd1;
   localparam logic [FIELD_W-1:0] F_HOUR  = 3'd2;
   localparam logic [FIELD_W-1:0] F_DAY   = 3'd3;
   localparam logic [FIELD_W-1:0] F_MONTH = 3'd4;
   localparam logic [FIELD_W-1:0] F_YEAR  = 3'd5;
   localparam logic [FIELD_W-1:0] F_CEN   = 3'd6;
   localparam logic [FIELD_W-1:0] F_NONE  = 3'd7;

   // Field edited in each SET state; RUN selects nothing.
   function automatic logic [FIELD_W-1:0] field_of(input state_e s);
      case (s)
         S_HOUR:  return F_HOUR;
         S_MIN:   return F_MIN;
         S_SEC:   return F_SEC;
         S_DAY:   return F_DAY;
         S_MONTH: return F_MONTH;
         S_YEAR:  return F_YEAR;
         S_CEN:   return F_CEN;
         default: return F_NONE;
      endcase
   endfunction

   function automatic state_e next_mode(input state_e s);
      case (s)
         RUN:     return S_HOUR;
         S_HOUR:  return S_MIN;
         S_MIN:   return S_SEC;
         S_SEC:   return S_DAY;
         S_DAY:   return S_MONTH;
         S_MONTH: return S_YEAR;
         S_YEAR:  return S_CEN;
         default: return RUN;
      endcase
   endfunction

   function automatic logic [NFIELD-1:0] field_strobe(input logic [FIELD_W-1:0] f);
      return (f == F_NONE) ? '0 : (NFIELD'(1) << f);
   endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a synchronised button level; with DATE_SET_AUTO_REPEAT_EN
// the enabled instance also emits hold-to-repeat pulses.
module btn_edge
`ifdef DATE_SET_AUTO_REPEAT_EN
#(
   parameter bit          HOLD_EN    = 1'b0,
   parameter int unsigned HOLD_CYC   = 3,
   parameter int unsigned REPEAT_CYC = 1
)
`endif
(
   input  logic clk_i,
   input  logic reset_i,
   input  logic lvl_i,
   input  logic kill_i,
   output logic pulse_o
);

   logic prev_q;
   logic rise;

   always_ff @(posedge clk_i) begin
      if (reset_i) prev_q <= 1'b0;
      else         prev_q <= lvl_i;
   end

   // kill_i suppresses the edge and restarts any hold in progress
   assign rise = lvl_i & ~prev_q & ~kill_i;

`ifdef DATE_SET_AUTO_REPEAT_EN
   generate
      if (HOLD_EN) begin : g_rep
         localparam int unsigned HW = (HOLD_CYC > 0)   ? $clog2(HOLD_CYC + 1) : 1;
         localparam int unsigned RW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC)   : 1;

         logic [HW-1:0] hold_q;
         logic [RW-1:0] rep_q;
         logic          at_hold;

         assign at_hold = (hold_q == HW'(HOLD_CYC));

         // hold_q saturates at HOLD_CYC, then rep_q paces the repeat strobes
         always_ff @(posedge clk_i) begin
            if (reset_i || kill_i || !lvl_i) begin
               hold_q <= '0;
               rep_q  <= '0;
            end else if (!at_hold) begin
               hold_q <= hold_q + HW'(1);
            end else if (rep_q == RW'(REPEAT_CYC - 1)) begin
               rep_q  <= '0;
            end else begin
               rep_q  <= rep_q + RW'(1);
            end
         end

         assign pulse_o = rise | (lvl_i & ~kill_i & at_hold & (rep_q == '0));
      end else begin : g_norep
         assign pulse_o = rise;
      end
   endgenerate
`else
   assign pulse_o = rise;
`endif

endmodule

// File: rtl/date_set_ctrl.sv
// Run/set mode controller for the clock's field counters.
// Optional hold-to-repeat on btn_inc: define DATE_SET_AUTO_REPEAT_EN.
module date_set_ctrl
   import date_set_pkg::*;
#(
   parameter int unsigned TIMEOUT    = 30
`ifdef DATE_SET_AUTO_REPEAT_EN
   ,
   parameter int unsigned HOLD_CYC   = 3,
   parameter int unsigned REPEAT_CYC = 1
`endif
) (
   input  logic                 sig_1Hz,
   input  logic                 reset,
   input  logic                 btn_mode,
   input  logic                 btn_inc,
   input  logic [NFIELD-2:0]    end_in,
   output logic                 run_en,
   output logic [NFIELD-1:0]    inc_b,
   output logic [NFIELD-1:0]    carry_o,
   output logic                 set_mode,
   output logic [FIELD_W-1:0]   field_sel,
   output logic                 blink
);

   localparam int unsigned IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [IDLE_W:0] TO_V = (IDLE_W + 1)'(TIMEOUT);

   state_e              state_q, state_d;
   logic [IDLE_W-1:0]   idle_q, idle_d;
   logic [IDLE_W:0]     idle_inc;
   logic                run_en_q, set_mode_q, blink_q;
   logic [NFIELD-1:0]   inc_q;
   logic [FIELD_W-1:0]  sel_q;
   logic                in_set, mode_rise, inc_pulse, inc_kill, fire;

   assign in_set   = (state_q != RUN);
   // Incs are dropped in RUN and lose to a simultaneous mode edge
   assign inc_kill = mode_rise | ~in_set;
   assign idle_inc = {1'b0, idle_q} + (IDLE_W + 1)'(1);

   btn_edge u_mode (
      .clk_i   (sig_1Hz),
      .reset_i (reset),
      .lvl_i   (btn_mode),
      .kill_i  (1'b0),
      .pulse_o (mode_rise)
   );

   btn_edge
`ifdef DATE_SET_AUTO_REPEAT_EN
   #(
      .HOLD_EN    (1'b1),
      .HOLD_CYC   (HOLD_CYC),
      .REPEAT_CYC (REPEAT_CYC)
   )
`endif
   u_inc (
      .clk_i   (sig_1Hz),
      .reset_i (reset),
      .lvl_i   (btn_inc),
      .kill_i  (inc_kill),
      .pulse_o (inc_pulse)
   );

   // Next state and idle count; any button activity or state change restarts idle
   always_comb begin
      state_d = state_q;
      idle_d  = '0;
      fire    = 1'b0;
      if (mode_rise) begin
         state_d = next_mode(state_q);
      end else if (in_set) begin
         fire = inc_pulse;
         if (!inc_pulse && (TIMEOUT != 0)) begin
            if (idle_inc == TO_V) state_d = RUN;
            else                  idle_d  = idle_inc[IDLE_W-1:0];
         end
      end
   end

   always_ff @(posedge sig_1Hz) begin
      if (reset) begin
         state_q    <= RUN;
         idle_q     <= '0;
         run_en_q   <= 1'b1;
         set_mode_q <= 1'b0;
         sel_q      <= F_NONE;
         blink_q    <= 1'b0;
         inc_q      <= '0;
      end else begin
         state_q    <= state_d;
         idle_q     <= idle_d;
         run_en_q   <= (state_d == RUN);
         set_mode_q <= (state_d != RUN);
         sel_q      <= field_of(state_d);
         blink_q    <= (state_d != RUN) && (state_d == state_q) && !blink_q;
         inc_q      <= fire ? field_strobe(field_of(state_q)) : '0;
      end
   end

   assign run_en    = run_en_q;
   assign set_mode  = set_mode_q;
   assign field_sel = sel_q;
   assign blink     = blink_q;
   assign inc_b     = inc_q;
   assign carry_o   = (state_q == RUN) ? {end_in, 1'b0} : '0;

endmodule

// File: tb/tb_date_set_ctrl.sv
// Self-checking bench for date_set_ctrl: vector table, directed corner sequences
// and randomized traffic against a behavioural model.
module tb_date_set_ctrl;

   localparam int TO   = 5;
   localparam int HOLD = 3;
   localparam int REP  = 1;
`ifdef DATE_SET_AUTO_REPEAT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, btn_mode, btn_inc;
   logic [5:0] end_in;
   logic       run_en, set_mode, blink;
   logic [6:0] inc_b, carry_o;
   logic [2:0] field_sel;
   logic [19:0] obs;

   always #5 clk = ~clk;

   date_set_ctrl #(
      .TIMEOUT    (TO)
`ifdef DATE_SET_AUTO_REPEAT_EN
      ,
      .HOLD_CYC   (HOLD),
      .REPEAT_CYC (REP)
`endif
   ) dut (
      .sig_1Hz   (clk),
      .reset     (reset),
      .btn_mode  (btn_mode),
      .btn_inc   (btn_inc),
      .end_in    (end_in),
      .run_en    (run_en),
      .inc_b     (inc_b),
      .carry_o   (carry_o),
      .set_mode  (set_mode),
      .field_sel (field_sel),
      .blink     (blink)
   );

   assign obs = {run_en, set_mode, field_sel, blink, inc_b, carry_o};

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behavioural model: mode 0 = RUN, 1..7 = hour, min, sec, day, month, year, century
   int         fld_tab [8] = '{7, 2, 1, 0, 3, 4, 5, 6};
   int         m_mode = 0, m_idle = 0, m_hold = 0;
   bit         m_pm = 0, m_pi = 0, m_blink = 0;
   logic [6:0] m_inc = '0;

   task automatic model_step(input bit rst, input bit bm, input bit bi);
      bit mr, ir, rep;
      int old;
      m_inc = '0;
      if (rst) begin
         m_mode = 0; m_idle = 0; m_hold = 0; m_blink = 0; m_pm = 0; m_pi = 0;
         return;
      end
      mr  = bm && !m_pm;
      ir  = bi && !m_pi;
      old = m_mode;
      rep = AUTO && bi && (m_hold >= HOLD) && (((m_hold - HOLD) % REP) == 0);
      if (mr) begin
         m_mode = (m_mode + 1) % 8;
         m_idle = 0;
      end else if (m_mode != 0) begin
         if (ir || rep) begin
            m_inc  = 7'(1) << fld_tab[m_mode];
            m_idle = 0;
         end else begin
            m_idle++;
            if (m_idle == TO) begin
               m_mode = 0;
               m_idle = 0;
            end
         end
      end
      m_blink = (m_mode != 0 && m_mode == old) ? !m_blink : 1'b0;
      m_hold  = (bi && old != 0 && !mr) ? m_hold + 1 : 0;
      m_pm    = bm;
      m_pi    = bi;
   endtask

   function automatic logic [19:0] model_obs(input logic [5:0] en);
      logic [6:0] c;
      c = (m_mode == 0) ? {en, 1'b0} : 7'd0;
      return {m_mode == 0, m_mode != 0, 3'(fld_tab[m_mode]), m_blink, m_inc, c};
   endfunction

   task automatic step(input bit rst, input bit bm, input bit bi, input logic [5:0] en);
      reset    = rst;
      btn_mode = bm;
      btn_inc  = bi;
      end_in   = en;
      @(posedge clk);
      #1;
      model_step(rst, bm, bi);
      check($sformatf("model_cyc%0d", cyc), 32'(obs), 32'(model_obs(en)));
      cyc++;
   endtask

   typedef struct {
      bit         rst;
      bit         bm;
      bit         bi;
      logic [5:0] en;
      bit         x_run;
      bit         x_set;
      logic [2:0] x_sel;
      logic [6:0] x_inc;
      logic [6:0] x_carry;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit r, input bit bm, input bit bi, input logic [5:0] en,
                      input bit xr, input bit xs, input logic [2:0] xsel,
                      input logic [6:0] xi, input logic [6:0] xc);
      tbl.push_back('{r, bm, bi, en, xr, xs, xsel, xi, xc});
   endtask

   task automatic press_mode(input int n);
      for (int k = 0; k < n; k++) begin
         step(0, 1, 0, 6'h3F);
         step(0, 0, 0, 6'h3F);
      end
   endtask

   int strobes;

   initial begin
      reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; end_in = '0;

      // reset, RUN pass-through, hour incs, walk to century, round trip, simultaneous edges
      add(1,0,0,6'h00, 1,0,3'd7,7'h00,7'h00);
      add(1,0,0,6'h00, 1,0,3'd7,7'h00,7'h00);
      add(0,0,0,6'h01, 1,0,3'd7,7'h00,7'h02);
      add(0,0,1,6'h3F, 1,0,3'd7,7'h00,7'h7E);
      add(0,0,0,6'h00, 1,0,3'd7,7'h00,7'h00);
      add(0,1,0,6'h3F, 0,1,3'd2,7'h00,7'h00);
      add(0,0,1,6'h3F, 0,1,3'd2,7'h04,7'h00);
      add(0,0,0,6'h3F, 0,1,3'd2,7'h00,7'h00);
      add(0,0,0,6'h3F, 0,1,3'd2,7'h00,7'h00);
      add(0,0,1,6'h3F, 0,1,3'd2,7'h04,7'h00);
      add(0,0,0,6'h3F, 0,1,3'd2,7'h00,7'h00);
      add(0,0,0,6'h3F, 0,1,3'd2,7'h00,7'h00);
      add(0,0,1,6'h3F, 0,1,3'd2,7'h04,7'h00);
      add(0,0,0,6'h3F, 0,1,3'd2,7'h00,7'h00);
      add(0,1,0,6'h3F, 0,1,3'd1,7'h00,7'h00);
      add(0,0,0,6'h3F, 0,1,3'd1,7'h00,7'h00);
      add(0,1,0,6'h3F, 0,1,3'd0,7'h00,7'h00);
      add(0,0,0,6'h3F, 0,1,3'd0,7'h00,7'h00);
      add(0,1,0,6'h3F, 0,1,3'd3,7'h00,7'h00);
      add(0,0,0,6'h3F, 0,1,3'd3,7'h00,7'h00);
      add(0,1,0,6'h3F, 0,1,3'd4,7'h00,7'h00);
      add(0,0,0,6'h3F, 0,1,3'd4,7'h00,7'h00);
      add(0,1,0,6'h3F, 0,1,3'd5,7'h00,7'h00);
      add(0,0,0,6'h3F, 0,1,3'd5,7'h00,7'h00);
      add(0,1,0,6'h3F, 0,1,3'd6,7'h00,7'h00);
      add(0,0,1,6'h3F, 0,1,3'd6,7'h40,7'h00);
      add(0,0,0,6'h3F, 0,1,3'd6,7'h00,7'h00);
      add(0,1,0,6'h3F, 1,0,3'd7,7'h00,7'h7E);
      add(0,0,0,6'h00, 1,0,3'd7,7'h00,7'h00);
      add(0,1,0,6'h15, 0,1,3'd2,7'h00,7'h00);
      add(0,0,0,6'h15, 0,1,3'd2,7'h00,7'h00);
      add(0,1,0,6'h15, 0,1,3'd1,7'h00,7'h00);
      add(0,0,0,6'h15, 0,1,3'd1,7'h00,7'h00);
      add(0,1,1,6'h15, 0,1,3'd0,7'h00,7'h00);
      add(0,0,1,6'h15, 0,1,3'd0,7'h00,7'h00);
      add(0,0,0,6'h15, 0,1,3'd0,7'h00,7'h00);
      add(1,0,0,6'h2A, 1,0,3'd7,7'h00,7'h54);

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].bm, tbl[i].bi, tbl[i].en);
         check($sformatf("row%0d", i),
               32'({run_en, set_mode, field_sel, inc_b, carry_o}),
               32'({tbl[i].x_run, tbl[i].x_set, tbl[i].x_sel, tbl[i].x_inc, tbl[i].x_carry}));
      end

      // Timeout from S_DAY: still in SET after 4 idle cycles, RUN on the 5th
      step(0, 0, 0, 6'h00);
      press_mode(3);
      step(0, 1, 0, 6'h00);
      check("day_entry_sel", 32'(field_sel), 32'd3);
      for (int k = 0; k < 4; k++) step(0, 0, 0, 6'h00);
      check("timeout_wait", 32'(set_mode), 32'd1);
      step(0, 0, 0, 6'h00);
      check("timeout_run", 32'({set_mode, run_en, field_sel}), 32'({1'b0, 1'b1, 3'd7}));

      // Timeout restarted by an inc on idle cycle 4
      press_mode(3);
      step(0, 1, 0, 6'h00);
      for (int k = 0; k < 3; k++) step(0, 0, 0, 6'h00);
      step(0, 0, 1, 6'h00);
      check("restart_inc", 32'(inc_b), 32'h08);
      for (int k = 0; k < 4; k++) step(0, 0, 0, 6'h00);
      check("restart_wait", 32'(set_mode), 32'd1);
      step(0, 0, 0, 6'h00);
      check("restart_run", 32'(set_mode), 32'd0);

`ifdef DATE_SET_AUTO_REPEAT_EN
      // Hold in S_YEAR: strobes on cycle 0 and cycles 3..7, then reset mid-hold
      press_mode(5);
      step(0, 1, 0, 6'h00);
      strobes = 0;
      for (int k = 0; k < 8; k++) begin
         step(0, 0, 1, 6'h00);
         if (inc_b == 7'h20) strobes++;
      end
      check("repeat_count", 32'(strobes), 32'd6);
      step(1, 0, 1, 6'h00);
      check("repeat_reset", 32'({set_mode, inc_b}), 32'h0);
      strobes = 0;
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 1, 6'h00);
         if (inc_b != 7'h00) strobes++;
      end
      check("repeat_after_reset", 32'(strobes), 32'd0);
`endif

      // Randomized traffic against the model
      step(1, 0, 0, 6'h00);
      for (int k = 0; k < 3000; k++)
         step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 2) == 0, 6'($urandom));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
